// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg
//   Shared definitions for the nibble-serial adder controller:
//   - state_t : controller FSM states (IDLE / BUSY / DONE)
//   - SLICE_W : width of one pass through the 4-bit CLA
package cla_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_seq_adder_cla4.sv
// cla_4bit
//   Purely combinational 4-bit carry-lookahead adder slice.
//   Ports:
//     a, b  : 4-bit addends
//     cin   : carry into bit 0
//     sum   : 4-bit sum
//     cout  : carry out of bit 3
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  for (genvar gi = 0; gi < 4; gi++) begin : g_pg
    assign g[gi]   = a[gi] & b[gi];
    assign p[gi]   = a[gi] ^ b[gi];
    assign sum[gi] = p[gi] ^ c[gi];
  end

  // Every carry is flattened to two-level logic from g/p and cin, so no
  // carry ripples through another slice bit.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
  assign cout = c[4];

endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder
//   Wide adder that time-shares one cla_4bit: operands are accepted over a
//   valid/ready handshake, summed one nibble per cycle LSB first with the
//   inter-slice carry held in a register, and the result is presented on a
//   valid/ready output port.  {cout, sum} = a + b + cin.
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     in_valid, in_ready    : operand handshake
//     a, b, cin             : WIDTH-bit operands and carry-in
//     out_valid, out_ready  : result handshake
//     sum, cout             : registered result, stable while out_valid
//     ovf                   : signed overflow (only with CLA_SEQ_OVF_EN)
//   Build option: define CLA_SEQ_OVF_EN to add the ovf output.
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
    $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t            state_reg;
  logic [IDXW-1:0]   idx_reg;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic              carry_reg;
  logic [WIDTH-1:0]  sum_reg;
  logic              cout_reg;
  logic              in_ready_reg;
  logic              out_valid_reg;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

  assign slice_a = a_reg[idx_reg*SLICE_W +: SLICE_W];
  assign slice_b = b_reg[idx_reg*SLICE_W +: SLICE_W];

  cla_4bit u_cla (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

`ifdef CLA_SEQ_OVF_EN
  logic ovf_reg;
  // At the last slice the top bit of the slice sum is the result MSB.
  logic ovf_next;
  assign ovf_next = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                    (slice_sum[SLICE_W-1] != a_reg[WIDTH-1]);
  assign ovf = ovf_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      carry_reg     <= 1'b0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      ovf_reg       <= 1'b0;
`endif
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= a;
            b_reg        <= b;
            carry_reg    <= cin;
            idx_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= BUSY;
          end
        end
        BUSY: begin
          sum_reg[idx_reg*SLICE_W +: SLICE_W] <= slice_sum;
          carry_reg <= slice_cout;
          if (idx_reg == LAST_IDX) begin
            cout_reg      <= slice_cout;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
`ifdef CLA_SEQ_OVF_EN
            ovf_reg       <= ovf_next;
`endif
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            idx_reg       <= '0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;
  assign cout      = cout_reg;

endmodule

// File: tb/tb_cla_seq_adder.sv
module tb_cla_seq_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef CLA_SEQ_OVF_EN
  logic        ovf;
`endif

  int n_cmp;
  int n_err;

  cla_seq_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef CLA_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present operands at a negedge, accept on the next posedge (T0).
  task automatic accept(input logic [15:0] av, input logic [15:0] bv,
                        input logic cv);
    @(negedge clk);
    check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
  endtask

  // Full operation: checks latency, result, and handshake release.
  task automatic do_op(input string tag, input logic [15:0] av,
                       input logic [15:0] bv, input logic cv,
                       input logic [15:0] exp_sum, input logic exp_cout);
    accept(av, bv, cv);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_valid_T3"}, {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid_T4"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_sum"}, {16'b0, sum}, {16'b0, exp_sum});
    check({tag, "_cout"}, {31'b0, cout}, {31'b0, exp_cout});
    $display("op %s: %h + %h + %0d -> sum=%h cout=%0d", tag, av, bv, cv, sum, cout);
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_release_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_release_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_sum", {16'b0, sum}, 32'd0);
    check("rst_cout", {31'b0, cout}, 32'd0);
`ifdef CLA_SEQ_OVF_EN
    check("rst_ovf", {31'b0, ovf}, 32'd0);
`endif
    rst_n = 1'b1;

    do_op("zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    release_result("zero");
    do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    release_result("ripple");
    do_op("mix", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);
    release_result("mix");
    do_op("allones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    release_result("allones");

    // Backpressure: result held while new operands are offered.
    do_op("bp", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
      @(posedge clk); #1;
      check("bp_sum", {16'b0, sum}, 32'h3333);
      check("bp_cout", {31'b0, cout}, 32'd0);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      $display("bp cycle %0d: sum=%h in_ready=%0d out_valid=%0d", k, sum, in_ready, out_valid);
    end
    in_valid = 1'b0;
    release_result("bp");
    check("bp_sum_after", {16'b0, sum}, 32'h3333);

    // Reset during slice 2 (computing between T2 and T3).
    accept(16'hABCD, 16'h1111, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_sum", {16'b0, sum}, 32'd0);
    check("midrst_cout", {31'b0, cout}, 32'd0);
    $display("mid-op reset: sum=%h in_ready=%0d out_valid=%0d", sum, in_ready, out_valid);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("postrst", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);
    release_result("postrst");

`ifdef CLA_SEQ_OVF_EN
    do_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
    check("ovf_pos_ovf", {31'b0, ovf}, 32'd1);
    release_result("ovf_pos");
    do_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    check("ovf_neg_ovf", {31'b0, ovf}, 32'd1);
    release_result("ovf_neg");
    do_op("ovf_none", 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1);
    check("ovf_none_ovf", {31'b0, ovf}, 32'd0);
    release_result("ovf_none");
`else
    do_op("msb", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    release_result("msb");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Nibble-serial wide-adder controller that time-shares a single `cla_4bit` instance to add two WIDTH-bit operands. It accepts one operation over a valid/ready handshake and feeds the operands through the 4-bit CLA one nibble per cycle, LSB first, holding the inter-slice carry in a register. It then presents the assembled sum and carry-out on a valid/ready result port. It sits between an operand source, such as a register file or bus interface, and any consumer needing wide addition without paying for a full-width CLA.

## Interface
- `WIDTH`, default 16: operand/result width.
  - Must be a multiple of 4 and ≥ 4. Any other value is an elaboration error.
- `NSLICE`, default `WIDTH/4`: derived local parameter giving the number of CLA passes.
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`, input, 1: rising-edge clock.
  - `rst_n`, input, 1: asynchronous active-low reset.
- Operand port:
  - `in_valid`, input, 1: operands are valid.
  - `in_ready`, output, 1: block can accept an operation.
  - `a`, input, WIDTH: operand A.
  - `b`, input, WIDTH: operand B.
  - `cin`, input, 1: carry-in.
- Result port:
  - `out_valid`, output, 1: result is valid.
  - `out_ready`, input, 1: consumer accepts the result.
  - `sum`, output, WIDTH: registered sum.
  - `cout`, output, 1: registered carry-out of the MSB.
- `ovf`, output, 1: signed overflow. Present only with `CLA_SEQ_OVF_EN`.

## Operation
- FSM states are `IDLE`, `BUSY` and `DONE`.
- `IDLE`:
  - `in_ready`=1.
  - On `in_valid && in_ready`:
    - latch `a`, `b` into operand registers;
    - load the carry register with `cin`;
    - set the slice index to 0;
    - enter `BUSY`.
- `BUSY`:
  - `in_ready`=0, `out_valid`=0.
  - Each cycle, the `cla_4bit` instance receives `a_r[4i+3:4i]`, `b_r[4i+3:4i]` and the carry register.
  - Its sum nibble is written into `sum_r[4i+3:4i]` and its carry-out into the carry register, then i increments.
  - When i == NSLICE-1 has been processed, enter `DONE`.
- `DONE`:
  - `out_valid`=1, `in_ready`=0.
  - `cout` equals the carry register.
  - On `out_ready`, return to `IDLE`.
- Arithmetic: `{cout, sum} = a + b + cin`, modulo 2^(WIDTH+1). Unsigned, with no saturation.
- Inputs during `BUSY`/`DONE`: `in_valid` is ignored and the operand inputs are don't-care.
- Reset values (all outputs):
  - `in_ready`=1;
  - `out_valid`=0;
  - `sum`=0;
  - `cout`=0;
  - `ovf`=0;
  - state `IDLE`, slice index 0, operand and carry registers 0.
- Reset mid-operation: the in-flight operation is discarded with no partial result. The block is in `IDLE` at the first clock edge after `rst_n` rises.
- The slice index counter wraps only via return to `IDLE`. It never exceeds NSLICE-1.

## Timing
- Acceptance edge is T0.
- Slice 0 computes during cycle T0→T1. Slice NSLICE-1 is written at edge T(NSLICE).
- `out_valid` rises at edge T(NSLICE). For WIDTH=16 that is 4 cycles after acceptance.
- Minimum initiation interval is NSLICE+2 cycles: `BUSY` × NSLICE, `DONE` ≥1, `IDLE` ≥1.
- `sum`/`cout`/`ovf` are registered and stable for the whole `DONE` period, including indefinite backpressure.
- There is no combinational path from `in_valid` or `out_ready` to any output other than through the FSM registers.

## Configuration
- `CLA_SEQ_OVF_EN`, when defined:
  - adds the `ovf` output;
  - `ovf` is computed at the last slice as `(a_r[MSB]==b_r[MSB]) && (sum[MSB]!=a_r[MSB])`;
  - `ovf` is registered alongside `sum` and valid in `DONE`.
- When `CLA_SEQ_OVF_EN` is undefined: the `ovf` port and its logic are absent, and all other behaviour is identical.

## Structure
- Package `cla_seq_pkg`:
  - FSM state enum (`IDLE`/`BUSY`/`DONE`);
  - slice width constant `SLICE_W`=4.
- Sub-module: one instance of the existing `cla_4bit`, which is the only adder hardware. No other arithmetic on the data path.
- The slice index is `$clog2(NSLICE)` bits, minimum 1.

## Test plan
All scenarios use WIDTH=16.
1. `a`=0x0000, `b`=0x0000, `cin`=0 → `sum`=0x0000, `cout`=0; `out_valid` exactly 4 cycles after the accept edge.
2. `a`=0xFFFF, `b`=0x0001, `cin`=0 → `sum`=0x0000, `cout`=1 (carry crosses all slice boundaries).
3. `a`=0x1234, `b`=0x4321, `cin`=1 → `sum`=0x5556, `cout`=0. Then `a`=0xFFFF, `b`=0xFFFF, `cin`=1 → `sum`=0xFFFF, `cout`=1.
4. Backpressure:
   - Stimulus: hold `out_ready`=0 for 5 cycles in `DONE`, pulsing `in_valid` with new operands.
   - Required: `sum`/`cout` stable, `in_ready`=0, new operands not captured.
   - After `out_ready`=1: `IDLE` next cycle.
5. Reset mid-operation:
   - Stimulus: assert `rst_n`=0 during slice 2 of 0xABCD+0x1111.
   - Required: all outputs return to reset values immediately.
   - After release: 0x0F0F+0x00F1 gives `sum`=0x1000, `cout`=0.
6. `CLA_SEQ_OVF_EN` defined:
   - 0x7FFF+0x0001 → `sum`=0x8000, `ovf`=1.
   - 0x8000+0x8000 → `sum`=0x0000, `cout`=1, `ovf`=1.
   - 0x0001+0xFFFF → `ovf`=0.
